// File: rtl/mem_port_arbiter_if.sv
// Request/response and ROM-drive bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters plus the ROM.
interface mem_port_arbiter_if #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
);
  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2 ** MEM_EXTRA) * 8;

  // Instruction-fetch requester.
  logic                 f_valid;
  logic                 f_ready;
  logic [AW-1:0]        f_addr;
  logic [MEM_EXTRA-1:0] f_extra;
  logic                 f_rsp_valid;

  // Data-load requester.
  logic                 l_valid;
  logic                 l_ready;
  logic [AW-1:0]        l_addr;
  logic [MEM_EXTRA-1:0] l_extra;
  logic [AW-1:0]        l_lower_bound;
  logic [AW-1:0]        l_upper_bound;
  logic                 l_rsp_valid;

  // Shared response.
  logic [DW-1:0]        rsp_data;
  logic                 rsp_error;

  // ROM port.
  logic [AW-1:0]        mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [AW-1:0]        mem_lower_bound;
  logic [AW-1:0]        mem_upper_bound;
  logic [DW-1:0]        mem_data;
  logic                 mem_error;

  modport slave (
    input  f_valid, f_addr, f_extra,
    input  l_valid, l_addr, l_extra, l_lower_bound, l_upper_bound,
    input  mem_data, mem_error,
    output f_ready, f_rsp_valid, l_ready, l_rsp_valid,
    output rsp_data, rsp_error,
    output mem_addr, mem_extra, mem_lower_bound, mem_upper_bound
  );

  modport master (
    output f_valid, f_addr, f_extra,
    output l_valid, l_addr, l_extra, l_lower_bound, l_upper_bound,
    output mem_data, mem_error,
    input  f_ready, f_rsp_valid, l_ready, l_rsp_valid,
    input  rsp_data, rsp_error,
    input  mem_addr, mem_extra, mem_lower_bound, mem_upper_bound
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one genrom read port between CPU fetch and load (IDLE/ISSUE/CAPTURE).
// Define MEM_PORT_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fetch priority.
module mem_port_arbiter #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int AW = MEM_DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  logic   gnt;        // 0 = fetch, 1 = load
  logic   pick_load;
  logic   accept;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  logic   last;       // 0 = fetch won last, 1 = load won last
`endif

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_load = 1'b0;
    if (bus.l_valid && !bus.f_valid) begin
      pick_load = 1'b1;
    end
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    else if (bus.l_valid && bus.f_valid) begin
      pick_load = ~last;
    end
`endif
  end

  // Ready is gated by reset so nothing handshakes while the block is held.
  assign bus.f_ready = (state == IDLE) && !reset && bus.f_valid && !pick_load;
  assign bus.l_ready = (state == IDLE) && !reset && bus.l_valid &&  pick_load;
  assign accept      = bus.f_ready || bus.l_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      gnt                 <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_extra       <= '0;
      bus.mem_lower_bound <= '0;
      bus.mem_upper_bound <= '1;
      bus.rsp_data        <= '0;
      bus.rsp_error       <= 1'b0;
      bus.f_rsp_valid     <= 1'b0;
      bus.l_rsp_valid     <= 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
      last                <= 1'b1;
`endif
    end else begin
      bus.f_rsp_valid <= 1'b0;
      bus.l_rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            gnt   <= bus.l_ready;
            state <= ISSUE;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
            last  <= bus.l_ready;
`endif
            if (bus.l_ready) begin
              bus.mem_addr        <= bus.l_addr;
              bus.mem_extra       <= bus.l_extra;
              bus.mem_lower_bound <= bus.l_lower_bound;
              bus.mem_upper_bound <= bus.l_upper_bound;
            end else begin
              // Fetch is unrestricted: the whole ROM is in bounds.
              bus.mem_addr        <= bus.f_addr;
              bus.mem_extra       <= bus.f_extra;
              bus.mem_lower_bound <= {AW{1'b0}};
              bus.mem_upper_bound <= {AW{1'b1}};
            end
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          bus.rsp_data    <= bus.mem_data;
          bus.rsp_error   <= bus.mem_error;
          bus.f_rsp_valid <= ~gnt;
          bus.l_rsp_valid <=  gnt;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_one_ready : assert property (@(posedge clk) disable iff (reset)
    !(bus.f_ready && bus.l_ready));
  a_one_rsp : assert property (@(posedge clk) disable iff (reset)
    !(bus.f_rsp_valid && bus.l_rsp_valid));
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle scoreboard model plus
// directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int DEPTH = 4;
  localparam int EXTRA = 4;
  localparam int AW    = DEPTH + 1;
  localparam int DW    = (2 ** EXTRA) * 8;
  localparam int ROM_TOP = (2 ** AW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.MEM_DEPTH(DEPTH), .MEM_EXTRA(EXTRA)) bus ();

  mem_port_arbiter #(.MEM_DEPTH(DEPTH), .MEM_EXTRA(EXTRA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM content: byte i holds value i; bytes addr..addr+extra packed with the
  // first byte most significant, right-aligned in the data word.
  function automatic logic [DW-1:0] rom_data(input int addr, input int extra);
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j <= extra; j++) d = {d[DW-9:0], 8'((addr + j) % 256)};
    return d;
  endfunction

  function automatic logic rom_err(input int addr, input int extra, input int lo, input int hi);
    return (addr < lo) || (addr + extra > hi) || (addr + extra > ROM_TOP);
  endfunction

  // Synchronous ROM: samples the drive at the edge, data valid next cycle.
  always @(posedge clk) begin
    bus.mem_data  <= rom_data(int'(bus.mem_addr), int'(bus.mem_extra));
    bus.mem_error <= rom_err(int'(bus.mem_addr), int'(bus.mem_extra),
                             int'(bus.mem_lower_bound), int'(bus.mem_upper_bound));
  end

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    logic          ld;
    int            addr, extra, lo, hi;
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } pend_t;

  pend_t         pend;
  bit            p_valid   = 1'b0;
  int            free_at   = 0;
  bit            last_load = 1'b1;
  logic [DW-1:0] hold_data = '0;
  logic          hold_err  = 1'b0;

  always @(negedge clk) begin : compare
    bit ef, el, erf, erl, win_l;
    if (cyc >= 1) begin
      ef = 1'b0; el = 1'b0; erf = 1'b0; erl = 1'b0; win_l = 1'b0;
      if (!reset && cyc >= free_at && (bus.f_valid || bus.l_valid)) begin
        if (bus.f_valid && bus.l_valid) begin
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
          win_l = !last_load;
`else
          win_l = 1'b0;
`endif
        end else begin
          win_l = bus.l_valid;
        end
        ef = !win_l;
        el = win_l;
      end
      check_i("f_ready", int'(bus.f_ready), int'(ef));
      check_i("l_ready", int'(bus.l_ready), int'(el));

      if (p_valid) begin
        check_i("mem_addr",  int'(bus.mem_addr),        pend.addr);
        check_i("mem_extra", int'(bus.mem_extra),       pend.extra);
        check_i("mem_lower", int'(bus.mem_lower_bound), pend.lo);
        check_i("mem_upper", int'(bus.mem_upper_bound), pend.hi);
      end

      if (p_valid && pend.due == cyc) begin
        hold_data = pend.data;
        hold_err  = pend.err;
        erf       = !pend.ld;
        erl       = pend.ld;
        p_valid   = 1'b0;
      end
      check_i("f_rsp_valid", int'(bus.f_rsp_valid), int'(erf));
      check_i("l_rsp_valid", int'(bus.l_rsp_valid), int'(erl));
      check_v("rsp_data",    bus.rsp_data,          hold_data);
      check_i("rsp_error",   int'(bus.rsp_error),   int'(hold_err));

      if (reset) begin
        p_valid   = 1'b0;
        free_at   = cyc + 1;
        last_load = 1'b1;
        hold_data = '0;
        hold_err  = 1'b0;
      end else if (ef || el) begin
        pend.ld = el;
        if (el) begin
          pend.addr  = int'(bus.l_addr);
          pend.extra = int'(bus.l_extra);
          pend.lo    = int'(bus.l_lower_bound);
          pend.hi    = int'(bus.l_upper_bound);
        end else begin
          pend.addr  = int'(bus.f_addr);
          pend.extra = int'(bus.f_extra);
          pend.lo    = 0;
          pend.hi    = ROM_TOP;
        end
        pend.data = rom_data(pend.addr, pend.extra);
        pend.err  = rom_err(pend.addr, pend.extra, pend.lo, pend.hi);
        pend.due  = cyc + 3;
        p_valid   = 1'b1;
        free_at   = cyc + 3;
        last_load = el;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit ld, input int addr, input int extra,
                     input int lo, input int hi, output int acc);
    if (ld) begin
      bus.l_valid       = 1'b1;
      bus.l_addr        = AW'(addr);
      bus.l_extra       = EXTRA'(extra);
      bus.l_lower_bound = AW'(lo);
      bus.l_upper_bound = AW'(hi);
    end else begin
      bus.f_valid = 1'b1;
      bus.f_addr  = AW'(addr);
      bus.f_extra = EXTRA'(extra);
    end
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ld ? bus.l_ready : bus.f_ready) begin
        acc = cyc;
        break;
      end
    end
    check_i(ld ? "l_accept_seen" : "f_accept_seen", int'(acc >= 0), 1);
    tick();
    if (ld) bus.l_valid = 1'b0;
    else    bus.f_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit ld, output int rc, output logic [DW-1:0] d,
                          output logic e, output logic other);
    rc = -1; d = '0; e = 1'b0; other = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ld ? bus.l_rsp_valid : bus.f_rsp_valid) begin
        rc    = cyc;
        d     = bus.rsp_data;
        e     = bus.rsp_error;
        other = ld ? bus.f_rsp_valid : bus.l_rsp_valid;
        break;
      end
    end
    check_i(ld ? "l_rsp_seen" : "f_rsp_seen", int'(rc >= 0), 1);
    tick();
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int            acc, rc, fa, la, fr, lr, g, first, lastc, seen;
    logic [DW-1:0] d;
    logic          e, o;
    string         order, exp_order;

    bus.f_valid = 1'b1; bus.f_addr = '0; bus.f_extra = '0;
    bus.l_valid = 1'b1; bus.l_addr = '0; bus.l_extra = '0;
    bus.l_lower_bound = '0; bus.l_upper_bound = '1;

    // Reset held two cycles with both requests valid.
    repeat (2) @(posedge clk);
    #1;
    check_i("rst_f_ready",     int'(bus.f_ready),         0);
    check_i("rst_l_ready",     int'(bus.l_ready),         0);
    check_i("rst_f_rsp_valid", int'(bus.f_rsp_valid),     0);
    check_i("rst_l_rsp_valid", int'(bus.l_rsp_valid),     0);
    check_i("rst_mem_addr",    int'(bus.mem_addr),        0);
    check_i("rst_mem_extra",   int'(bus.mem_extra),       0);
    check_i("rst_mem_lower",   int'(bus.mem_lower_bound), 0);
    check_i("rst_mem_upper",   int'(bus.mem_upper_bound), 31);
    check_v("rst_rsp_data",    bus.rsp_data,              '0);
    check_i("rst_rsp_error",   int'(bus.rsp_error),       0);
    reset = 1'b0;
    bus.f_valid = 1'b0;
    bus.l_valid = 1'b0;
    tick();

    // Single fetch: bytes 3..6.
    req(1'b0, 3, 3, 0, 31, acc);
    wait_rsp(1'b0, rc, d, e, o);
    check_i("fetch_latency", rc - acc, 3);
    check_v("fetch_data", d, DW'(32'h03040506));
    check_i("fetch_error", int'(e), 0);
    check_i("fetch_no_l_rsp", int'(o), 0);

    // Load outside its bounds.
    req(1'b1, 8, 0, 0, 4, acc);
    wait_rsp(1'b1, rc, d, e, o);
    check_i("oob_latency", rc - acc, 3);
    check_i("oob_error", int'(e), 1);
    check_i("oob_no_f_rsp", int'(o), 0);

    // Both requesters held valid across four grants.
    bus.f_addr = AW'(1); bus.f_extra = '0;
    bus.l_addr = AW'(2); bus.l_extra = '0;
    bus.l_lower_bound = '0; bus.l_upper_bound = AW'(31);
    bus.f_valid = 1'b1; bus.l_valid = 1'b1;
    order = ""; g = 0; first = -1; lastc = -1;
    for (int i = 0; i < 60 && g < 4; i++) begin
      @(negedge clk);
      if (bus.f_ready || bus.l_ready) begin
        order = {order, bus.f_ready ? "F" : "L"};
        g++;
        if (first < 0) first = cyc;
        lastc = cyc;
      end
    end
    tick();
    bus.f_valid = 1'b0; bus.l_valid = 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    exp_order = "FLFL";
`else
    exp_order = "FFFF";
`endif
    check_s("arb_order", order, exp_order);
    check_i("arb_span", lastc - first, 9);
    repeat (4) tick();

    // Back-to-back: load offered while the fetch response is pending.
    req(1'b0, 5, 1, 0, 31, fa);
    bus.l_valid = 1'b1; bus.l_addr = AW'(10); bus.l_extra = EXTRA'(2);
    bus.l_lower_bound = '0; bus.l_upper_bound = AW'(31);
    la = -1; fr = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.f_rsp_valid) fr = cyc;
      if (bus.l_ready) begin
        la = cyc;
        break;
      end
    end
    tick();
    bus.l_valid = 1'b0;
    wait_rsp(1'b1, lr, d, e, o);
    check_i("b2b_f_latency", fr - fa, 3);
    check_i("b2b_l_accept",  la - fa, 3);
    check_i("b2b_l_latency", lr - la, 3);
    check_v("b2b_l_data", d, DW'(24'h0a0b0c));
    check_i("b2b_l_error", int'(e), 0);

    // Reset during CAPTURE drops the in-flight response.
    req(1'b0, 0, 0, 0, 31, acc);  // now in ISSUE
    tick();                        // now in CAPTURE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.f_rsp_valid || bus.l_rsp_valid) seen = 1;
    end
    tick();
    check_i("rst_capture_no_rsp", seen, 0);
    req(1'b0, 7, 3, 0, 31, acc);
    wait_rsp(1'b0, rc, d, e, o);
    check_i("post_rst_latency", rc - acc, 3);
    check_v("post_rst_data", d, DW'(32'h0708090a));

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
